// File: rtl/vga_pattern_gen.sv
// VGA timing plus per-game-state test pattern (bars, flash, solid fill).
// Latency: one pixel from counter value to registered pins; one pixel = CLK_DIV clocks.
// Backpressure: none; free-running raster, state input is sampled once per frame.
//
// Ports:
//    clock, reset        : system clock, synchronous active-high reset
//    state[1:0]          : game state 0 running, 1 hit, 2 fail, 3 ending
//    frame_start         : one-clock pulse with the output pixel at h=0, v=0
//    de, x, y            : display enable and visible coordinates (x=y=0 when de=0)
//    hs, vs              : syncs, active level HS_POL / VS_POL
//    red, green, blue    : COLOR_BITS-wide colour channels, 0 outside the visible area
module vga_pattern_gen #(
   parameter int CLK_DIV      = 2,
   parameter int H_ACTIVE     = 640,
   parameter int H_FP         = 16,
   parameter int H_SYNC       = 96,
   parameter int H_BP         = 48,
   parameter int V_ACTIVE     = 480,
   parameter int V_FP         = 10,
   parameter int V_SYNC       = 2,
   parameter int V_BP         = 33,
   parameter bit HS_POL       = 1'b0,
   parameter bit VS_POL       = 1'b0,
   parameter int COLOR_BITS   = 4,
   parameter int NUM_BARS     = 8,
   parameter int FLASH_FRAMES = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [1:0]            state,
   output logic                  frame_start,
   output logic                  de,
   output logic [11:0]           x,
   output logic [11:0]           y,
   output logic                  hs,
   output logic                  vs,
   output logic [COLOR_BITS-1:0] red,
   output logic [COLOR_BITS-1:0] green,
   output logic [COLOR_BITS-1:0] blue
);

   localparam int H_T   = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_T   = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int BAR_W = H_ACTIVE / NUM_BARS;
   localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BB    = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
   localparam int FW    = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

   localparam logic [11:0]   H_LAST     = 12'(H_T - 1);
   localparam logic [11:0]   V_LAST     = 12'(V_T - 1);
   localparam logic [11:0]   H_SYNC_E   = 12'(H_SYNC);
   localparam logic [11:0]   V_SYNC_E   = 12'(V_SYNC);
   localparam logic [11:0]   H_ACT_S    = 12'(H_SYNC + H_BP);
   localparam logic [11:0]   H_ACT_E    = 12'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [11:0]   V_ACT_S    = 12'(V_SYNC + V_BP);
   localparam logic [11:0]   V_ACT_E    = 12'(V_SYNC + V_BP + V_ACTIVE);
   localparam logic [11:0]   BAR_W_LAST = 12'(BAR_W - 1);
   localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
   localparam logic [BB-1:0] BAR_LAST   = BB'(NUM_BARS - 1);
   localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_FRAMES - 1);

   localparam logic [1:0] ST_RUN  = 2'd0;
   localparam logic [1:0] ST_HIT  = 2'd1;
   localparam logic [1:0] ST_FAIL = 2'd2;
   localparam logic [1:0] ST_END  = 2'd3;

   logic [DW-1:0]         r_div;
   logic [11:0]           r_h, r_v;
   logic [11:0]           r_bar_pix;
   logic [BB-1:0]         r_bar;
   logic [FW-1:0]         r_flash_cnt;
   logic                  r_flash_ph;
   logic [1:0]            r_state_q;
   logic                  r_fs, r_de, r_hs, r_vs;
   logic [11:0]           r_x, r_y;
   logic [COLOR_BITS-1:0] r_red, r_green, r_blue;

   logic                  w_pix_en, w_h_wrap, w_frame_wrap;
   logic                  w_h_act, w_v_act, w_act;
   logic [11:0]           w_x, w_y;
   logic [2:0]            w_pal;
   logic [COLOR_BITS-1:0] w_red, w_green, w_blue;

   always_comb begin
      w_pix_en     = (r_div == DIV_LAST);
      w_h_wrap     = (r_h == H_LAST);
      w_frame_wrap = w_h_wrap && (r_v == V_LAST);
      w_h_act      = (r_h >= H_ACT_S) && (r_h < H_ACT_E);
      w_v_act      = (r_v >= V_ACT_S) && (r_v < V_ACT_E);
      w_act        = w_h_act && w_v_act;
      w_x          = w_act ? (r_h - H_ACT_S) : 12'd0;
      w_y          = w_act ? (r_v - V_ACT_S) : 12'd0;
      w_pal        = 3'(r_bar);
   end

   // Pattern for the pixel the counters currently point at; gated to black off-screen.
   always_comb begin
      w_red   = '0;
      w_green = '0;
      w_blue  = '0;
      if (w_act) begin
         case (r_state_q)
            ST_RUN: begin
               case (w_pal)
                  3'd0:    w_red = '1;
                  3'd1:    w_green = '1;
                  3'd2:    w_blue = '1;
                  3'd3:    begin w_red = '1; w_green = '1; w_blue = '1; end
                  3'd4:    ;
                  3'd5:    begin w_red = '1; w_green = '1; end
                  3'd6:    begin w_red = '1; w_blue = '1; end
                  default: begin w_green = '1; w_blue = '1; end
               endcase
            end
            ST_HIT:  if (r_flash_ph) w_red = '1;
            ST_FAIL: if (r_bar[0]) begin w_red = '1; w_green = '1; w_blue = '1; end
            default: w_green = '1;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_div       <= '0;
         r_h         <= '0;
         r_v         <= '0;
         r_bar_pix   <= '0;
         r_bar       <= '0;
         r_flash_cnt <= '0;
         r_flash_ph  <= 1'b0;
         r_state_q   <= ST_RUN;
         r_fs        <= 1'b0;
         r_de        <= 1'b0;
         r_x         <= '0;
         r_y         <= '0;
         r_hs        <= ~HS_POL;
         r_vs        <= ~VS_POL;
         r_red       <= '0;
         r_green     <= '0;
         r_blue      <= '0;
      end else begin
         r_div <= w_pix_en ? '0 : r_div + DW'(1);
         // frame_start must be one clock wide, not one pixel wide.
         r_fs  <= 1'b0;
         if (w_pix_en) begin
            r_h <= w_h_wrap ? 12'd0 : r_h + 12'd1;
            if (w_h_wrap) r_v <= (r_v == V_LAST) ? 12'd0 : r_v + 12'd1;

            // Width counter follows h; it is held at 0 outside the active span so
            // the first active pixel of every line starts in bar 0.
            if (w_h_act) begin
               if (r_bar_pix == BAR_W_LAST) begin
                  r_bar_pix <= '0;
                  if (r_bar != BAR_LAST) r_bar <= r_bar + BB'(1);
               end else begin
                  r_bar_pix <= r_bar_pix + 12'd1;
               end
            end else begin
               r_bar_pix <= '0;
               r_bar     <= '0;
            end

            // State is only taken at the frame seam so a frame never mixes patterns.
            if (w_frame_wrap) begin
               r_state_q <= state;
               if ((state == ST_HIT) && (r_state_q != ST_HIT)) begin
                  r_flash_cnt <= '0;
                  r_flash_ph  <= 1'b1;
               end else if (r_flash_cnt == FLASH_LAST) begin
                  r_flash_cnt <= '0;
                  r_flash_ph  <= ~r_flash_ph;
               end else begin
                  r_flash_cnt <= r_flash_cnt + FW'(1);
               end
            end

            r_fs    <= (r_h == 12'd0) && (r_v == 12'd0);
            r_de    <= w_act;
            r_x     <= w_x;
            r_y     <= w_y;
            r_hs    <= (r_h < H_SYNC_E) ? HS_POL : ~HS_POL;
            r_vs    <= (r_v < V_SYNC_E) ? VS_POL : ~VS_POL;
            r_red   <= w_red;
            r_green <= w_green;
            r_blue  <= w_blue;
         end
      end
   end

   assign frame_start = r_fs;
   assign de          = r_de;
   assign x           = r_x;
   assign y           = r_y;
   assign hs          = r_hs;
   assign vs          = r_vs;
   assign red         = r_red;
   assign green       = r_green;
   assign blue        = r_blue;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: small-raster instance A (CLK_DIV=2, 8 bars,
// FLASH_FRAMES=2), instance B (CLK_DIV=1, HS_POL=1, 4 bars, 8-bit colour) and a
// default-parameter instance C used for full-size line timing.
module tb_vga_pattern_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [1:0] st_a, st_b, st_c;

   logic        fs_a, de_a, hs_a, vs_a;
   logic [11:0] x_a, y_a;
   logic [3:0]  r_a, g_a, b_a;
   logic [11:0] rgb_a;
   assign rgb_a = {r_a, g_a, b_a};

   logic        fs_b, de_b, hs_b, vs_b;
   logic [11:0] x_b, y_b;
   logic [7:0]  r_b, g_b, b_b;
   logic [23:0] rgb_b;
   assign rgb_b = {r_b, g_b, b_b};

   logic        fs_c, de_c, hs_c, vs_c;
   logic [11:0] x_c, y_c;
   logic [3:0]  r_c, g_c, b_c;

   vga_pattern_gen #(
      .CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .HS_POL(1'b0), .VS_POL(1'b0),
      .COLOR_BITS(4), .NUM_BARS(8), .FLASH_FRAMES(2)
   ) u_a (
      .clock(clk), .reset(rst), .state(st_a), .frame_start(fs_a), .de(de_a),
      .x(x_a), .y(y_a), .hs(hs_a), .vs(vs_a), .red(r_a), .green(g_a), .blue(b_a)
   );

   vga_pattern_gen #(
      .CLK_DIV(1), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b0),
      .COLOR_BITS(8), .NUM_BARS(4), .FLASH_FRAMES(1)
   ) u_b (
      .clock(clk), .reset(rst), .state(st_b), .frame_start(fs_b), .de(de_b),
      .x(x_b), .y(y_b), .hs(hs_b), .vs(vs_b), .red(r_b), .green(g_b), .blue(b_b)
   );

   vga_pattern_gen u_c (
      .clock(clk), .reset(rst), .state(st_c), .frame_start(fs_c), .de(de_c),
      .x(x_c), .y(y_c), .hs(hs_c), .vs(vs_c), .red(r_c), .green(g_c), .blue(b_c)
   );

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Results of one scan of instance A from one frame_start to the next.
   logic [11:0] img [0:5][0:15];
   int  sc_len, sc_de, sc_blank_bad, sc_hs, sc_vs, sc_fx, sc_fy, sc_lx, sc_ly;
   bit  sc_ok;

   task automatic scan_a(input int sw_y, input logic [1:0] sw_st);
      sc_len = 0; sc_de = 0; sc_blank_bad = 0; sc_hs = 0; sc_vs = 0;
      sc_fx = -1; sc_fy = -1; sc_lx = -1; sc_ly = -1; sc_ok = 0;
      for (int yy = 0; yy < 6; yy++)
         for (int xx = 0; xx < 16; xx++)
            img[yy][xx] = 12'hBAD;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         sc_len++;
         if (!hs_a) sc_hs++;
         if (!vs_a) sc_vs++;
         if (de_a) begin
            if (sc_de == 0) begin sc_fx = int'(x_a); sc_fy = int'(y_a); end
            sc_de++;
            sc_lx = int'(x_a); sc_ly = int'(y_a);
            if (int'(y_a) < 6 && int'(x_a) < 16) img[int'(y_a)][int'(x_a)] = rgb_a;
            if (sw_y >= 0 && int'(y_a) == sw_y && x_a == 12'd0) st_a = sw_st;
         end else if (x_a != 12'd0 || y_a != 12'd0 || rgb_a != 12'd0) begin
            sc_blank_bad++;
         end
         if (fs_a) begin sc_ok = 1; break; end
      end
      chk("scan_a_found_fs", 32'(sc_ok), 32'd1);
   endtask

   function automatic bit act(input int sel);
      return (sel == 0) ? !hs_c : hs_b;
   endfunction

   // Width (active clocks) and period (clocks between assertions) of a sync.
   task automatic meas(input int sel, output int w, output int p);
      bit prev, cur, found;
      w = -1; p = -1; found = 0;
      prev = act(sel);
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         cur = act(sel);
         if (!prev && cur) begin found = 1; break; end
         prev = cur;
      end
      if (found) begin
         prev = 1'b1;
         for (int i = 1; i <= 4000; i++) begin
            @(negedge clk);
            cur = act(sel);
            if (w < 0 && !cur) w = i;
            if (!prev && cur) begin p = i; break; end
            prev = cur;
         end
      end
   endtask

   task automatic wait_b(input int xx, output logic [23:0] c, output bit ok);
      ok = 0; c = '0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (de_b && int'(x_b) == xx) begin ok = 1; c = rgb_b; break; end
      end
   endtask

   int          t_a, t_b, w, p;
   bit          ok;
   logic [23:0] cb;
   logic [11:0] hit_exp [0:4];

   initial begin
      hit_exp[0] = 12'hF00; hit_exp[1] = 12'hF00; hit_exp[2] = 12'h000;
      hit_exp[3] = 12'h000; hit_exp[4] = 12'hF00;
      rst = 1'b1; st_a = 2'd0; st_b = 2'd0; st_c = 2'd0;
      repeat (3) @(negedge clk);

      chk("rst_hs_a", 32'(hs_a), 32'd1);
      chk("rst_vs_a", 32'(vs_a), 32'd1);
      chk("rst_de_a", 32'(de_a), 32'd0);
      chk("rst_xy_a", {8'd0, x_a, y_a}, 32'd0);
      chk("rst_rgb_a", 32'(rgb_a), 32'd0);
      chk("rst_fs_a", 32'(fs_a), 32'd0);
      chk("rst_hs_b", 32'(hs_b), 32'd0);
      chk("rst_vs_b", 32'(vs_b), 32'd1);
      chk("rst_c", {18'd0, hs_c, vs_c, de_c, fs_c, r_c, g_c, b_c}, 32'h0000C000);
      chk("rst_xy_c", {8'd0, x_c, y_c}, 32'd0);

      // First frame_start: one pixel after release (A: 2 clocks, B: 1 clock).
      rst = 1'b0;
      t_a = -1; t_b = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (fs_b && t_b < 0) t_b = i;
         if (fs_a) begin t_a = i; break; end
      end
      chk("first_fs_a", 32'(t_a), 32'd2);
      chk("first_fs_b", 32'(t_b), 32'd1);
      chk("fs_b_one_clock", 32'(fs_b), 32'd0);

      // Frame 1: running colour bars and raster geometry.
      scan_a(-1, 2'd0);
      chk("frame_clocks", 32'(sc_len), 32'd506);
      chk("de_clocks", 32'(sc_de), 32'd192);
      chk("blank_zero", 32'(sc_blank_bad), 32'd0);
      chk("hs_low_clocks", 32'(sc_hs), 32'd66);
      chk("vs_low_clocks", 32'(sc_vs), 32'd92);
      chk("first_de_xy", {sc_fx[15:0], sc_fy[15:0]}, 32'h0000_0000);
      chk("last_de_xy", {sc_lx[15:0], sc_ly[15:0]}, 32'h000F_0005);
      chk("run_x0", 32'(img[0][0]), 32'hF00);
      chk("run_x2", 32'(img[0][2]), 32'h0F0);
      chk("run_x6", 32'(img[0][6]), 32'hFFF);
      chk("run_x8", 32'(img[3][8]), 32'h000);
      chk("run_x15", 32'(img[5][15]), 32'h0FF);

      // Frame 2: switch to ending at y=3; the rest of this frame stays running.
      scan_a(3, 2'd3);
      chk("sw_keep_y2", 32'(img[2][0]), 32'hF00);
      chk("sw_keep_y4", 32'(img[4][0]), 32'hF00);
      chk("sw_keep_y5", 32'(img[5][2]), 32'h0F0);

      // Frame 3: ending is solid green; request hit for the next frame.
      scan_a(0, 2'd1);
      chk("end_x0", 32'(img[0][0]), 32'h0F0);
      chk("end_x8", 32'(img[3][8]), 32'h0F0);
      chk("end_x15", 32'(img[5][15]), 32'h0F0);

      // Frames 4..8: hit flashes 2 red, 2 black, 2 red; fail requested in frame 8.
      for (int k = 0; k < 5; k++) begin
         scan_a((k == 4) ? 0 : -1, 2'd2);
         chk($sformatf("hit_frame%0d", k), 32'(img[2][5]), 32'(hit_exp[k]));
      end

      // Frame 9: fail, black even bars / white odd bars.
      scan_a(-1, 2'd2);
      chk("fail_x0", 32'(img[1][0]), 32'h000);
      chk("fail_x2", 32'(img[1][2]), 32'hFFF);
      chk("fail_x4", 32'(img[1][4]), 32'h000);
      chk("fail_x15", 32'(img[1][15]), 32'hFFF);

      // Instance B: CLK_DIV=1, active-high hs, 4 bars of width 4, 8-bit colour.
      meas(1, w, p);
      chk("b_hs_high", 32'(w), 32'd4);
      chk("b_line", 32'(p), 32'd24);
      wait_b(0, cb, ok);  chk("b_x0_found", 32'(ok), 32'd1);  chk("b_x0", 32'(cb), 32'hFF0000);
      wait_b(4, cb, ok);  chk("b_x4_found", 32'(ok), 32'd1);  chk("b_x4", 32'(cb), 32'h00FF00);
      wait_b(8, cb, ok);  chk("b_x8_found", 32'(ok), 32'd1);  chk("b_x8", 32'(cb), 32'h0000FF);
      wait_b(12, cb, ok); chk("b_x12_found", 32'(ok), 32'd1); chk("b_x12", 32'(cb), 32'hFFFFFF);

      // Instance C: default 640x480 timing, hs low 96 px x 2 clocks, line 800 x 2.
      meas(0, w, p);
      chk("c_hs_low", 32'(w), 32'd192);
      chk("c_line", 32'(p), 32'd1600);

      // Mid-line, mid-frame reset on A (state input still fail).
      ok = 0;
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         if (de_a && y_a == 12'd2 && x_a == 12'd7) begin ok = 1; break; end
      end
      chk("rst_point_found", 32'(ok), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_sync", {26'd0, hs_a, vs_a, de_a, fs_a, hs_b, 1'b0}, 32'h30);
      chk("mid_rst_xy", {8'd0, x_a, y_a}, 32'd0);
      chk("mid_rst_rgb", 32'(rgb_a), 32'd0);
      rst = 1'b0;
      t_a = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (fs_a) begin t_a = i; break; end
      end
      chk("mid_rst_fs1", 32'(t_a), 32'd2);
      scan_a(-1, 2'd2);
      chk("mid_rst_fs2", 32'(t_a + sc_len), 32'd508);
      chk("mid_rst_running", 32'(img[0][2]), 32'h0F0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
Parametrised successor to the fixed 640x480 colour-bar VGA driver. Generates VGA timing from the system clock using a pixel-enable divider, with configurable timing, sync polarity, colour depth and bar count. Renders one pattern per game state (running, hit, fail, ending), with a frame-counted flash for hit. Latches state only at frame boundaries so the picture never tears. Sits between the game FSM and the VGA connector.

Parameters:
CLK_DIV, 2, system clocks per pixel (>=1)
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, active level of hs
VS_POL, 0, active level of vs
COLOR_BITS, 4, bits per colour channel
NUM_BARS, 8, colour bars per line; H_ACTIVE must be divisible by NUM_BARS
FLASH_FRAMES, 16, frames per flash half-period in hit state (>=1)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
state  in  2  game state: 0 running, 1 hit, 2 fail, 3 ending
frame_start  out  1  one-clock pulse aligned with output pixel (h=0, v=0)
de  out  1  display enable, high on visible pixels
x  out  12  visible column, 0..H_ACTIVE-1; 0 when de=0
y  out  12  visible row, 0..V_ACTIVE-1; 0 when de=0
hs  out  1  horizontal sync
vs  out  1  vertical sync
red  out  COLOR_BITS  red channel
green  out  COLOR_BITS  green channel
blue  out  COLOR_BITS  blue channel

Behaviour:
- One clock domain, clock. Reset is synchronous and active-high.
- Reset: divider, h_cnt, v_cnt, bar index, flash counter and flash phase all 0; state_q=running. Outputs: hs=!HS_POL, vs=!VS_POL, de=0, x=y=0, rgb=0, frame_start=0.
- Divider counts 0..CLK_DIV-1; pix_en is high when the count is CLK_DIV-1. With CLK_DIV=1, pix_en is high every cycle. The divider runs from the first cycle after reset.
- Counters and outputs advance only on pix_en. Outputs hold between pix_en cycles.
- Line period H_T = H_SYNC+H_BP+H_ACTIVE+H_FP. h_cnt wraps H_T-1 -> 0.
- Frame period V_T = V_SYNC+V_BP+V_ACTIVE+V_FP. v_cnt increments only at h wrap, and wraps V_T-1 -> 0 at that same h wrap.
- Region ordering starts at count 0: sync, back porch, active, front porch.
- hs is active while h_cnt < H_SYNC. vs is active while v_cnt < V_SYNC.
- Active region is h in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and v in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE). Both bounds are exclusive at the top.
- x = h_cnt-(H_SYNC+H_BP) and y = v_cnt-(V_SYNC+V_BP) during the active region.
- All outputs are registered from the same counter values in the same stage, giving one-pixel latency. hs, vs, de, x, y, rgb and frame_start are mutually aligned.
- state_q <= state on the pix_en where v_cnt and h_cnt both wrap to 0. A mid-frame state change takes effect at the next frame.
- Bar index = x / (H_ACTIVE/NUM_BARS). Track it with a width counter, not a divider. It resets at the start of each active line and saturates at NUM_BARS-1.
- F denotes all-ones at COLOR_BITS width. When de=0, rgb=0.
- running: palette by bar index mod 8: red(F,0,0), green(0,F,0), blue(0,0,F), white(F,F,F), black(0,0,0), yellow(F,F,0), magenta(F,0,F), cyan(0,F,F).
- hit: rgb=(F,0,0) when flash_phase=1, else black.
- fail: black on even bars, white on odd bars.
- ending: solid green.
- Flash counter increments once per frame (at frame wrap) in every state. At FLASH_FRAMES-1 it returns to 0 and toggles flash_phase.
- Entering hit (state_q changes to hit) clears the flash counter and sets flash_phase=1, so the first hit frame is red.
- Reset asserted mid-line or mid-frame returns to the reset values on the next clock edge. Timing restarts from h=v=0.

Test Plan:
- Defaults, release reset: hs is low for 192 clocks per line; line period 1600 clocks; vs low for 2 lines; frame = 525 lines = 840000 clocks; frame_start pulses once per 840000 clocks, width 1 clock.
- running: each line has 640 de pixels and each frame 480 de lines; x=0 -> (F,0,0), x=80 -> (0,F,0), x=320 -> (0,0,0), x=639 -> (0,F,F); first de aligns with x=0, last with x=639; x=y=0 and rgb=0 when de=0.
- Switch state to ending mid-frame (y=200): remainder of the frame is unchanged; from the next frame_start every visible pixel is (0,F,0).
- hit with FLASH_FRAMES=2: frames alternate 2 red, 2 black, 2 red; fail: x=0 black, x=80 white.
- CLK_DIV=1, HS_POL=1, NUM_BARS=4, COLOR_BITS=8: hs is high for 96 clocks; line = 800 clocks; bar width 160; x=160 -> (0,FF,0).
- Assert reset at h=400, v=100 for 1 cycle: outputs take reset values the next edge; next frame_start arrives exactly one full frame after reset release, plus the one-pixel latency.
